// File: rtl/jstk2_spi_master_pkg.sv
// Shared definitions for the JSTK2 SPI master: FSM encoding, protocol constants
// and a counter-width helper.
package jstk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_CS_HOLD,
        ST_WAIT
    } jstk_state_e;

    localparam logic [7:0] CMD_SET_LED  = 8'h84;
    localparam int         NUM_BYTES    = 5;
    localparam int         BTN_JOY_BIT  = 0;
    localparam int         BTN_TRIG_BIT = 1;

    // Down-counters load at most (max - 1), so $clog2(max) bits are enough.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/jstk2_spi_master_if.sv
// System-side and pad-side signals of the JSTK2 SPI master, grouped with
// master (the block) and slave (its environment) views.
interface jstk2_spi_master_if;

    logic        enable;
    logic [23:0] led_rgb;
    logic        jstk_miso;
    logic        jstk_sck;
    logic        jstk_mosi;
    logic        jstk_cs;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic        btn_joy;
    logic        btn_trig;
    logic        data_valid;
    logic        busy;

    modport master (
        input  enable, led_rgb, jstk_miso,
        output jstk_sck, jstk_mosi, jstk_cs,
        output x_pos, y_pos, btn_joy, btn_trig, data_valid, busy
    );

    modport slave (
        output enable, led_rgb, jstk_miso,
        input  jstk_sck, jstk_mosi, jstk_cs,
        input  x_pos, y_pos, btn_joy, btn_trig, data_valid, busy
    );

endinterface

// File: rtl/jstk2_spi_master_spi_byte_shift.sv
// SPI mode-0 byte engine: SCK half-period divider plus an 8-bit MSB-first
// shift register, with a start pulse in and a done strobe out.
module spi_byte_shift #(
    parameter int SCLK_HALF = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic       miso_i,
    output logic       sck_o,
    output logic       mosi_o,
    output logic       done_o,
    output logic [7:0] rx_byte_o
);

    localparam int            HW        = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);

    logic          miso_meta_q, miso_sync_q;
    logic          run_q, sck_q;
    logic [HW-1:0] half_q;
    logic [2:0]    bit_q;
    logic [7:0]    tx_sh_q, rx_sh_q;

    logic          active;
    logic          tick;
    logic [HW-1:0] half_eff;

    // The start cycle already counts as the first cycle of bit 7's low phase.
    assign active    = run_q | start_i;
    assign half_eff  = run_q ? half_q : HALF_LAST;
    assign tick      = active && (half_eff == '0);
    assign done_o    = run_q && sck_q && tick && (bit_q == 3'd0);
    assign rx_byte_o = {rx_sh_q[6:0], miso_sync_q};
    assign sck_o     = sck_q;
    assign mosi_o    = run_q ? tx_sh_q[7] : tx_byte_i[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
            run_q       <= 1'b0;
            sck_q       <= 1'b0;
            half_q      <= '0;
            bit_q       <= 3'd0;
            tx_sh_q     <= 8'h00;
            rx_sh_q     <= 8'h00;
        end else begin
            miso_meta_q <= miso_i;
            miso_sync_q <= miso_meta_q;
            if (start_i && !run_q) begin
                run_q   <= 1'b1;
                tx_sh_q <= tx_byte_i;
                bit_q   <= 3'd7;
            end
            if (active) begin
                if (tick) begin
                    half_q <= HALF_LAST;
                    if (!sck_q) begin
                        sck_q <= 1'b1;
                    end else begin
                        // Falling edge: capture MISO and present the next MOSI bit.
                        sck_q   <= 1'b0;
                        rx_sh_q <= rx_byte_o;
                        tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                        if (bit_q == 3'd0) run_q <= 1'b0;
                        else               bit_q <= bit_q - 3'd1;
                    end
                end else begin
                    half_q <= half_eff - HW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/jstk2_spi_master.sv
// Pmod JSTK2 poller: sequences CS, five SPI bytes and inter-byte gaps, then
// publishes X/Y/buttons with a one-cycle strobe. JSTK_LED_EN enables LED colour TX.
module jstk2_spi_master
    import jstk_pkg::*;
#(
    parameter int SCLK_HALF    = 60,
    parameter int CS_SETUP_CYC = 1500,
    parameter int BYTE_GAP_CYC = 1000,
    parameter int POLL_CYC     = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    jstk2_spi_master_if.master bus
);

    localparam int CNT_W = cnt_width(SCLK_HALF, CS_SETUP_CYC, BYTE_GAP_CYC, POLL_CYC);

`ifdef JSTK_LED_EN
    localparam logic [7:0] FIRST_TX = CMD_SET_LED;
`else
    localparam logic [7:0] FIRST_TX = 8'h00;
`endif

    jstk_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       byte_idx_q;
    logic             start_q;
    logic [7:0]       tx_byte_q;
    logic [7:0]       tx_next_d;
    logic             cs_q, busy_q, dv_q;
    logic [7:0]       x_lo_q, y_lo_q;
    logic [1:0]       x_hi_q, y_hi_q, btn_q;
    logic [9:0]       x_q, y_q;
    logic             joy_q, trig_q;

    logic             sh_sck, sh_mosi, sh_done;
    logic [7:0]       sh_rx;

    spi_byte_shift #(.SCLK_HALF(SCLK_HALF)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_q),
        .tx_byte_i (tx_byte_q),
        .miso_i    (bus.jstk_miso),
        .sck_o     (sh_sck),
        .mosi_o    (sh_mosi),
        .done_o    (sh_done),
        .rx_byte_o (sh_rx)
    );

`ifdef JSTK_LED_EN
    logic [23:0] led_q;

    always_ff @(posedge clk) begin
        if (rst)                                   led_q <= 24'h0;
        else if (state_q == ST_IDLE && bus.enable) led_q <= bus.led_rgb;
    end

    always_comb begin
        case (byte_idx_q)
            3'd0:    tx_next_d = led_q[23:16];
            3'd1:    tx_next_d = led_q[15:8];
            3'd2:    tx_next_d = led_q[7:0];
            default: tx_next_d = 8'h00;
        endcase
    end
`else
    assign tx_next_d = 8'h00;
`endif

    // WAIT plus the single IDLE cycle together span POLL_CYC clocks of CS high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_idx_q <= 3'd0;
            start_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            dv_q       <= 1'b0;
            x_lo_q     <= 8'h00;
            y_lo_q     <= 8'h00;
            x_hi_q     <= 2'b00;
            y_hi_q     <= 2'b00;
            btn_q      <= 2'b00;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            joy_q      <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            dv_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state_q    <= ST_CS_SETUP;
                        cnt_q      <= CNT_W'(CS_SETUP_CYC - 1);
                        byte_idx_q <= 3'd0;
                        tx_byte_q  <= FIRST_TX;
                        cs_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_CS_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_SHIFT;
                        start_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        case (byte_idx_q)
                            3'd0:    x_lo_q <= sh_rx;
                            3'd1:    x_hi_q <= sh_rx[1:0];
                            3'd2:    y_lo_q <= sh_rx;
                            3'd3:    y_hi_q <= sh_rx[1:0];
                            default: btn_q  <= {sh_rx[BTN_TRIG_BIT], sh_rx[BTN_JOY_BIT]};
                        endcase
                        if (byte_idx_q == 3'(NUM_BYTES - 1)) begin
                            state_q   <= ST_CS_HOLD;
                            cnt_q     <= CNT_W'(SCLK_HALF - 1);
                            tx_byte_q <= 8'h00;
                        end else begin
                            state_q   <= ST_GAP;
                            cnt_q     <= CNT_W'(BYTE_GAP_CYC - 1);
                            tx_byte_q <= tx_next_d;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_q    <= ST_SHIFT;
                        start_q    <= 1'b1;
                        byte_idx_q <= byte_idx_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_CS_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CNT_W'(POLL_CYC - 2);
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        dv_q    <= 1'b1;
                        x_q     <= {x_hi_q, x_lo_q};
                        y_q     <= {y_hi_q, y_lo_q};
                        joy_q   <= btn_q[0];
                        trig_q  <= btn_q[1];
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) state_q <= ST_IDLE;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.jstk_sck   = sh_sck;
    assign bus.jstk_mosi  = sh_mosi;
    assign bus.jstk_cs    = cs_q;
    assign bus.busy       = busy_q;
    assign bus.data_valid = dv_q;
    assign bus.x_pos      = x_q;
    assign bus.y_pos      = y_q;
    assign bus.btn_joy    = joy_q;
    assign bus.btn_trig   = trig_q;

endmodule
